// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life frame stepper: FSM encoding, cell rule
// constants, neighbour-count helper and the read-latency legality check.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BIRTH_N   = 4'd3;
  localparam logic [3:0] SURVIVE_N = 4'd2;

  function automatic logic rd_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic logic [3:0] nbr_count(input logic [7:0] nbrs);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int k = 0; k < 8; k++) begin
      cnt = cnt + {3'b000, nbrs[k]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/life_row_next.sv
// Combinational next-generation rule for one row, given the rows above and below.
// Bit X_SIZE-1 is column 0; wrap=1 makes the outer columns neighbours.
module life_row_next
  import life_pkg::*;
#(
  parameter int X_SIZE = 1280
) (
  input  logic              wrap,
  input  logic [X_SIZE-1:0] top,
  input  logic [X_SIZE-1:0] mid,
  input  logic [X_SIZE-1:0] bot,
  output logic [X_SIZE-1:0] nxt
);

  for (genvar i = 0; i < X_SIZE; i++) begin : g_cell
    // LI is the column to the left (higher bit), RI the column to the right.
    localparam int LI = (i == X_SIZE - 1) ? 0 : i + 1;
    localparam int RI = (i == 0) ? X_SIZE - 1 : i - 1;

    logic       en_l;
    logic       en_r;
    logic [3:0] n;

    assign en_l = (i == X_SIZE - 1) ? wrap : 1'b1;
    assign en_r = (i == 0) ? wrap : 1'b1;

    assign n = nbr_count({top[LI] & en_l, top[i], top[RI] & en_r,
                          mid[LI] & en_l,          mid[RI] & en_r,
                          bot[LI] & en_l, bot[i], bot[RI] & en_r});

    assign nxt[i] = (n == BIRTH_N) | (mid[i] & (n == SURVIVE_N));
  end

endmodule

// File: rtl/life_frame_stepper.sv
// Computes one Game-of-Life generation by streaming rows from the source bank
// through a three-row window; define LIFE_WRAP_EN for a toroidal universe.
module life_frame_stepper
  import life_pkg::*;
#(
  parameter int X_SIZE = 1280,
  parameter int Y_SIZE = 720,
  parameter int RD_LAT = 1,
  localparam int Y_WIDTH = $clog2(Y_SIZE)
) (
  input  logic               out_stream_aclk,
  input  logic               periph_resetn,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               bank_sel,
  output logic [31:0]        gen_count,
  output logic               rd_en,
  output logic [Y_WIDTH-1:0] rd_addr,
  input  logic [X_SIZE-1:0]  rd_data,
  output logic               wr_en,
  output logic [Y_WIDTH-1:0] wr_addr,
  output logic [X_SIZE-1:0]  wr_data
);

  // state | meaning
  // IDLE  | waiting for start (ignored while pause or abort is high)
  // RUN   | issuing read slots, filling the window, writing next-state rows
  // DONE  | one cycle: done pulsed, bank swapped, generation counted

  if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
    $error("life_frame_stepper: RD_LAT must be 1 or 2");
  end

`ifdef LIFE_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif

  // Slot and capture counters must reach Y_SIZE+1, hence one extra bit.
  localparam int SW = Y_WIDTH + 1;
  localparam logic [SW-1:0]      SLOT_LAST = SW'(Y_SIZE + 1);
  localparam logic [Y_WIDTH-1:0] ROW_LAST  = Y_WIDTH'(Y_SIZE - 1);

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bank_q, bank_d;
  logic [31:0]         gen_q, gen_d;
  logic                rd_en_q, rd_en_d;
  logic [Y_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [Y_WIDTH-1:0]  wr_addr_q, wr_addr_d;
  logic [SW-1:0]       slot_cnt_q, slot_cnt_d;
  logic                slot_act_q, slot_act_d;
  logic                slot_zero_q, slot_zero_d;
  logic [RD_LAT-1:0]   vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0]   zero_pipe_q, zero_pipe_d;
  logic [SW-1:0]       cap_cnt_q, cap_cnt_d;
  logic [X_SIZE-1:0]   top_q, top_d, mid_q, mid_d, bot_q, bot_d;

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bank_d      = bank_q;
    gen_d       = gen_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    slot_cnt_d  = slot_cnt_q;
    slot_act_d  = 1'b0;
    slot_zero_d = 1'b0;
    vld_pipe_d  = vld_pipe_q << 1;
    vld_pipe_d[0]  = slot_act_q;
    zero_pipe_d = zero_pipe_q << 1;
    zero_pipe_d[0] = slot_zero_q;
    cap_cnt_d   = cap_cnt_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !pause && !abort) begin
          state_d     = ST_RUN;
          busy_d      = 1'b1;
          rd_en_d     = WRAP;
          rd_addr_d   = ROW_LAST;
          slot_act_d  = 1'b1;
          slot_zero_d = !WRAP;
          slot_cnt_d  = SW'(1);
          cap_cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          vld_pipe_d  = '0;
          zero_pipe_d = '0;
        end else begin
          if (slot_cnt_q <= SLOT_LAST) begin
            slot_act_d = 1'b1;
            slot_cnt_d = slot_cnt_q + SW'(1);
            if (slot_cnt_q == SLOT_LAST) begin
              rd_addr_d   = '0;
              rd_en_d     = WRAP;
              slot_zero_d = !WRAP;
            end else begin
              rd_addr_d = Y_WIDTH'(slot_cnt_q - SW'(1));
              rd_en_d   = 1'b1;
            end
          end
          // Boundary slots without wrap shift in a dead row instead of rd_data.
          if (vld_pipe_q[RD_LAT-1]) begin
            top_d     = mid_q;
            mid_d     = bot_q;
            bot_d     = zero_pipe_q[RD_LAT-1] ? '0 : rd_data;
            cap_cnt_d = cap_cnt_q + SW'(1);
            if (cap_cnt_q >= SW'(2)) begin
              wr_en_d   = 1'b1;
              wr_addr_d = Y_WIDTH'(cap_cnt_q - SW'(2));
            end
          end
          if (wr_en_q && (wr_addr_q == ROW_LAST)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            bank_d  = !bank_q;
            gen_d   = gen_q + 32'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bank_q      <= 1'b0;
      gen_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      slot_cnt_q  <= '0;
      slot_act_q  <= 1'b0;
      slot_zero_q <= 1'b0;
      vld_pipe_q  <= '0;
      zero_pipe_q <= '0;
      cap_cnt_q   <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bank_q      <= bank_d;
      gen_q       <= gen_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      slot_cnt_q  <= slot_cnt_d;
      slot_act_q  <= slot_act_d;
      slot_zero_q <= slot_zero_d;
      vld_pipe_q  <= vld_pipe_d;
      zero_pipe_q <= zero_pipe_d;
      cap_cnt_q   <= cap_cnt_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
    end
  end

  life_row_next #(.X_SIZE(X_SIZE)) u_row_next (
    .wrap (WRAP),
    .top  (top_q),
    .mid  (mid_q),
    .bot  (bot_q),
    .nxt  (wr_data)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign bank_sel  = bank_q;
  assign gen_count = gen_q;
  assign rd_en     = rd_en_q;
  assign rd_addr   = rd_addr_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_life_frame_stepper.sv
// Directed bench for life_frame_stepper: an RD_LAT=1 and an RD_LAT=2 instance on
// an 8x6 universe, each with a two-bank memory model.
module tb_life_frame_stepper;

  localparam int X = 8;
  localparam int Y = 6;

  localparam logic [47:0] BLINK      = {8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h00};
  localparam logic [47:0] BLINK_NEXT = {8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00};
  localparam logic [47:0] BLOCK      = {8'h00, 8'h18, 8'h18, 8'h00, 8'h00, 8'h00};
  localparam logic [47:0] EDGE       = {8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00};
  localparam logic [47:0] FILL       = {6{8'hA5}};
`ifdef LIFE_WRAP_EN
  localparam logic [7:0] EDGE_R1 = 8'hC1;
`else
  localparam logic [7:0] EDGE_R1 = 8'hC0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, pause = 1'b0, abort = 1'b0;

  always #5 clk = ~clk;

  logic        busy1, done1, bank1, rd_en1, wr_en1;
  logic [31:0] gen1;
  logic [2:0]  rd_addr1, wr_addr1;
  logic [7:0]  rd_data1, wr_data1;
  logic        busy2, done2, bank2, rd_en2, wr_en2;
  logic [31:0] gen2;
  logic [2:0]  rd_addr2, wr_addr2;
  logic [7:0]  rd_data2, wr_data2;

  life_frame_stepper #(.X_SIZE(X), .Y_SIZE(Y), .RD_LAT(1)) u_dut1 (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start), .pause(pause), .abort(abort),
    .busy(busy1), .done(done1), .bank_sel(bank1), .gen_count(gen1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1));

  life_frame_stepper #(.X_SIZE(X), .Y_SIZE(Y), .RD_LAT(2)) u_dut2 (
    .out_stream_aclk(clk), .periph_resetn(rst_n), .start(start), .pause(pause), .abort(abort),
    .busy(busy2), .done(done2), .bank_sel(bank2), .gen_count(gen2),
    .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2));

  // Memory model; reads with rd_en low return all-ones so a missing zero row shows up.
  logic [7:0] mem1 [2][Y];
  logic [7:0] mem2 [2][Y];
  logic       ld_en = 1'b0, ld_bank = 1'b0;
  logic [2:0] ld_row = '0;
  logic [7:0] ld_val = '0;
  logic [7:0] rdq1, rdq2a, rdq2b;

  always @(posedge clk) begin
    if (ld_en) begin
      mem1[ld_bank][ld_row] <= ld_val;
      mem2[ld_bank][ld_row] <= ld_val;
    end
    if (wr_en1) mem1[~bank1][wr_addr1] <= wr_data1;
    if (wr_en2) mem2[~bank2][wr_addr2] <= wr_data2;
    rdq1  <= rd_en1 ? mem1[bank1][rd_addr1] : 8'hFF;
    rdq2a <= rd_en2 ? mem2[bank2][rd_addr2] : 8'hFF;
    rdq2b <= rdq2a;
  end
  assign rd_data1 = rdq1;
  assign rd_data2 = rdq2b;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int t0 = 0, cur_rel = 0;
  int fw1, lw1, nw1, dc1, nd1;
  int fw2, lw2, nw2, dc2, nd2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_frame(input logic bank, input logic [47:0] f);
    for (int r = 0; r < Y; r++) begin
      @(negedge clk);
      ld_en = 1'b1; ld_bank = bank; ld_row = 3'(r); ld_val = f[47-8*r -: 8];
    end
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    cur_rel = 0;
    @(posedge clk);
    #1 start = 1'b0;
    fw1 = -1; lw1 = -1; nw1 = 0; dc1 = -1; nd1 = 0;
    fw2 = -1; lw2 = -1; nw2 = 0; dc2 = -1; nd2 = 0;
  endtask

  // Advance to relative cycle c, recording write/done activity of both instances.
  task automatic to_cycle(input int c);
    while (cur_rel < c) begin
      @(negedge clk);
      cur_rel = cyc - t0;
      if (wr_en1) begin if (fw1 < 0) fw1 = cur_rel; lw1 = cur_rel; nw1++; end
      if (wr_en2) begin if (fw2 < 0) fw2 = cur_rel; lw2 = cur_rel; nw2++; end
      if (done1) begin dc1 = cur_rel; nd1++; end
      if (done2) begin dc2 = cur_rel; nd2++; end
    end
  endtask

  task automatic chk_rows(input string tag, input logic bank, input logic [47:0] f);
    for (int r = 0; r < Y; r++) begin
      chk($sformatf("%s_lat1_row%0d", tag, r), {24'd0, mem1[bank][r]}, {24'd0, f[47-8*r -: 8]});
      chk($sformatf("%s_lat2_row%0d", tag, r), {24'd0, mem2[bank][r]}, {24'd0, f[47-8*r -: 8]});
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl1"}, {21'd0, busy1, done1, bank1, rd_en1, wr_en1, rd_addr1, wr_addr1}, 32'd0);
    chk({tag, "_gen1"}, gen1, 32'd0);
    chk({tag, "_ctl2"}, {21'd0, busy2, done2, bank2, rd_en2, wr_en2, rd_addr2, wr_addr2}, 32'd0);
    chk({tag, "_gen2"}, gen2, 32'd0);
  endtask

  initial begin
    // Asynchronous reset: outputs clear before any clock edge.
    #3 rst_n = 1'b0;
    #1 chk_quiet("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Abort at cycle 6.
    load_frame(1'b0, BLINK);
    load_frame(1'b1, FILL);
    kick();
    to_cycle(6);
    abort = 1'b1;
    to_cycle(7);
    chk("abort_busy1", {31'd0, busy1}, 32'd0);
    chk("abort_busy2", {31'd0, busy2}, 32'd0);
    abort = 1'b0;
    to_cycle(14);
    chk("abort_done1", nd1, 0);
    chk("abort_done2", nd2, 0);
    chk("abort_last_wr1", lw1, 6);
    chk("abort_nwr1", nw1, 2);
    chk("abort_nwr2", nw2, 1);
    chk("abort_bank", {30'd0, bank1, bank2}, 32'd0);
    chk("abort_gen1", gen1, 32'd0);
    chk("abort_row2_untouched", {24'd0, mem1[1][2]}, 32'hA5);
    chk("abort_row5_untouched", {24'd0, mem2[1][5]}, 32'hA5);

    // Abort and start together in IDLE: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_start_busy", {30'd0, busy1, busy2}, 32'd0);

    // Start while paused is ignored.
    pause = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("pause_busy", {30'd0, busy1, busy2}, 32'd0);
    repeat (2) @(negedge clk);
    chk("pause_rd_en", {30'd0, rd_en1, rd_en2}, 32'd0);
    pause = 1'b0;

    // Blinker, with a start at cycle 3 that must be ignored.
    load_frame(1'b1, FILL);
    kick();
    to_cycle(1);
    chk("blink_busy_c1", {30'd0, busy1, busy2}, 32'd3);
    to_cycle(3);
    start = 1'b1;
    to_cycle(4);
    start = 1'b0;
    to_cycle(14);
    chk("blink_first_wr1", fw1, 5);
    chk("blink_first_wr2", fw2, 6);
    chk("blink_nwr1", nw1, 6);
    chk("blink_nwr2", nw2, 6);
    chk("blink_done1", dc1, 11);
    chk("blink_done2", dc2, 12);
    chk("blink_ndone1", nd1, 1);
    chk("blink_bank", {30'd0, bank1, bank2}, 32'd3);
    chk("blink_gen1", gen1, 32'd1);
    chk("blink_gen2", gen2, 32'd1);
    chk("blink_busy_end", {30'd0, busy1, busy2}, 32'd0);
    chk_rows("blink", 1'b1, BLINK_NEXT);

    // Still-life block.
    load_frame(1'b1, BLOCK);
    load_frame(1'b0, FILL);
    kick();
    to_cycle(14);
    chk("block_first_wr1", fw1, 5);
    chk("block_last_wr1", lw1, 10);
    chk("block_nwr1", nw1, 6);
    chk("block_done1", dc1, 11);
    chk("block_bank", {30'd0, bank1, bank2}, 32'd0);
    chk("block_gen1", gen1, 32'd2);
    chk_rows("block", 1'b0, BLOCK);

    // Left-edge column, exercising column wrap and dead boundary rows.
    load_frame(1'b0, EDGE);
    load_frame(1'b1, FILL);
    kick();
    to_cycle(14);
    chk("edge_row0_lat1", {24'd0, mem1[1][0]}, 32'h00);
    chk("edge_row1_lat1", {24'd0, mem1[1][1]}, {24'd0, EDGE_R1});
    chk("edge_row1_lat2", {24'd0, mem2[1][1]}, {24'd0, EDGE_R1});
    chk("edge_row5_lat1", {24'd0, mem1[1][5]}, 32'h00);
    chk("edge_gen1", gen1, 32'd3);

    // Reset at cycle 8 of a generation, then a clean generation.
    load_frame(1'b1, BLINK);
    load_frame(1'b0, FILL);
    kick();
    to_cycle(8);
    rst_n = 1'b0;
    #1 chk_quiet("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_row3_lat1", {24'd0, mem1[0][3]}, 32'hA5);
    chk("midreset_row4_lat1", {24'd0, mem1[0][4]}, 32'hA5);
    chk("midreset_row2_lat2", {24'd0, mem2[0][2]}, 32'hA5);

    load_frame(1'b0, BLINK);
    load_frame(1'b1, FILL);
    kick();
    to_cycle(14);
    chk("restart_done1", dc1, 11);
    chk("restart_done2", dc2, 12);
    chk("restart_gen1", gen1, 32'd1);
    chk("restart_bank", {30'd0, bank1, bank2}, 32'd3);
    chk_rows("restart", 1'b1, BLINK_NEXT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
